// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin arbiter sharing one UART transmitter among three byte streams.
// Optional stall timeout is built only when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       link_ready,
    input  logic       tx_busy,
    input  logic       tx_block,
    input  logic [7:0] r0_data,
    input  logic       r0_valid,
    input  logic       r0_last,
    output logic       r0_ready,
    input  logic [7:0] r1_data,
    input  logic       r1_valid,
    input  logic       r1_last,
    output logic       r1_ready,
    input  logic [7:0] r2_data,
    input  logic       r2_valid,
    input  logic       r2_last,
    output logic       r2_ready,
    output logic [7:0] tx_data,
    output logic       new_tx_data,
    output logic       grant_active,
    output logic [1:0] grant_id,
    output logic       timeout
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GRANT  = 2'd1;
    localparam logic [1:0] S_ISSUE  = 2'd2;
    localparam logic [1:0] NO_GRANT = 2'd3;

    logic [1:0] r_state;
    logic [1:0] r_grant;
    logic [1:0] r_last_grant;
    logic       r_grant_active;
    logic       r_new_tx_data;
    logic       r_byte_last;
    logic [7:0] r_tx_data;

    logic [2:0] w_valid;
    logic       w_any;
    logic [1:0] w_start;
    logic [1:0] w_pick;
    logic [2:0] w_cand;
    logic       w_g_valid;
    logic       w_g_last;
    logic [7:0] w_g_data;
    logic       w_issue;
    logic       w_timeout_hit;

    assign w_valid = {r2_valid, r1_valid, r0_valid};
    assign w_any   = |w_valid;

    always_comb begin
        w_g_valid = 1'b0;
        w_g_last  = 1'b0;
        w_g_data  = '0;
        case (r_grant)
            2'd0: begin
                w_g_valid = r0_valid;
                w_g_last  = r0_last;
                w_g_data  = r0_data;
            end
            2'd1: begin
                w_g_valid = r1_valid;
                w_g_last  = r1_last;
                w_g_data  = r1_data;
            end
            2'd2: begin
                w_g_valid = r2_valid;
                w_g_last  = r2_last;
                w_g_data  = r2_data;
            end
            default: ;
        endcase
    end

    // Walk from the farthest candidate to the nearest so the nearest valid one wins.
    always_comb begin
        w_start = (r_last_grant == 2'd2) ? 2'd0 : r_last_grant + 2'd1;
        w_pick  = NO_GRANT;
        w_cand  = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            w_cand = {1'b0, w_start} + 3'(2 - i);
            if (w_cand >= 3'd3) begin
                w_cand = w_cand - 3'd3;
            end
            if (w_valid[w_cand[1:0]]) begin
                w_pick = w_cand[1:0];
            end
        end
    end

    assign w_issue = rst_n && (r_state == S_GRANT) && w_g_valid && !tx_busy
                     && !tx_block && link_ready;

    assign r0_ready = w_issue && (r_grant == 2'd0);
    assign r1_ready = w_issue && (r_grant == 2'd1);
    assign r2_ready = w_issue && (r_grant == 2'd2);

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_timeout;
    logic             w_stall;

    assign w_stall       = (r_state == S_GRANT) && !w_g_valid;
    assign w_timeout_hit = w_stall && (r_stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= w_timeout_hit && link_ready;
            if (w_stall && !w_timeout_hit) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end else begin
                r_stall_cnt <= '0;
            end
        end
    end

    assign timeout = r_timeout;
`else
    logic [31:0] w_unused_cfg;

    assign w_unused_cfg  = TIMEOUT_CYCLES;
    assign w_timeout_hit = 1'b0;
    assign timeout       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_grant        <= NO_GRANT;
            r_last_grant   <= 2'd2;
            r_grant_active <= 1'b0;
            r_tx_data      <= '0;
            r_new_tx_data  <= 1'b0;
            r_byte_last    <= 1'b0;
        end else begin
            r_new_tx_data <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (link_ready && w_any) begin
                        r_grant        <= w_pick;
                        r_grant_active <= 1'b1;
                        r_state        <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (!link_ready || w_timeout_hit) begin
                        r_last_grant   <= r_grant;
                        r_grant        <= NO_GRANT;
                        r_grant_active <= 1'b0;
                        r_state        <= S_IDLE;
                    end else if (w_issue) begin
                        r_tx_data     <= w_g_data;
                        r_new_tx_data <= 1'b1;
                        r_byte_last   <= w_g_last;
                        r_state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!link_ready || r_byte_last) begin
                        r_last_grant   <= r_grant;
                        r_grant        <= NO_GRANT;
                        r_grant_active <= 1'b0;
                        r_state        <= S_IDLE;
                    end else begin
                        r_state <= S_GRANT;
                    end
                end
                default: begin
                    r_grant        <= NO_GRANT;
                    r_grant_active <= 1'b0;
                    r_state        <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_data      = r_tx_data;
    assign new_tx_data  = r_new_tx_data;
    assign grant_active = r_grant_active;
    assign grant_id     = r_grant;

endmodule
